// File: rtl/echo_arb_pkg.sv
// echo_arb_pkg: shared types, constants and helpers for the echo arbiter.
package echo_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W = 16;
  typedef logic [2:0] tag_t;
  function automatic logic [7:0] onehot_of(tag_t tag);
    return 8'(1) << tag;
  endfunction
endpackage

// File: rtl/echo_arb_tagq.sv
// echo_arb_tagq: in-order FIFO of requester tags; reset clears pointers only.
module echo_arb_tagq
  import echo_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  tag_t          din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output tag_t          head
);
  localparam int AW = $clog2(DEPTH);
  tag_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign head  = mem_q[rd_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/echo_arbiter.sv
// echo_arbiter: round-robin share of one FIFO-ordered echo engine among NREQ requesters.
// Optional ECHO_ARB_STATS_EN adds per-requester grant counters and a high-water mark.
module echo_arbiter
  import echo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req__ENA,
  input  logic [NREQ*DATA_W-1:0] req_v,
  output logic [NREQ-1:0]        req__RDY,
  output logic                   echoReq__ENA,
  output logic [DATA_W-1:0]      echoReq_v,
  input  logic                   echoReq__RDY,
  input  logic                   ind_echo__ENA,
  input  logic [DATA_W-1:0]      ind_echo_v,
  output logic [NREQ-1:0]        rsp__ENA,
  output logic [DATA_W-1:0]      rsp_v,
  output logic [CW-1:0]          outstanding,
`ifdef ECHO_ARB_STATS_EN
  output logic [NREQ*CNT_W-1:0]  grant_cnt,
  output logic [CW-1:0]          max_outstanding,
`endif
  output logic                   err_orphan
);
  logic              full, empty, push, pop, can_grant;
  tag_t              head, gidx, ptr_q, ptr_d;
  logic [7:0]        head_oh;
  logic [NREQ-1:0]   gnt, rsp_ena_q, rsp_ena_d;
  logic [DATA_W-1:0] rsp_v_q, rsp_v_d;
  logic              orphan_q;
  int                idx;
  echo_arb_tagq #(.DEPTH(DEPTH), .CW(CW)) u_tagq (
    .clk(CLK), .rst_n(nRST), .push(push), .pop(pop), .din(gidx),
    .full(full), .empty(empty), .count(outstanding), .head(head)
  );
  // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    gnt       = '0;
    gidx      = '0;
    idx       = 0;
    can_grant = nRST & echoReq__RDY & ~full;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (can_grant && gnt == '0 && req__ENA[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = tag_t'(idx);
      end
    end
    push      = |gnt;
    echoReq_v = req_v[int'(gidx)*DATA_W +: DATA_W];
    ptr_d     = push ? tag_t'((int'(gidx) + 1) % NREQ) : ptr_q;
  end
  assign req__RDY     = gnt;
  assign echoReq__ENA = push;
  assign pop          = ind_echo__ENA & ~empty;
  assign head_oh      = onehot_of(head);
  assign rsp_ena_d    = pop ? head_oh[NREQ-1:0] : '0;
  assign rsp_v_d      = pop ? ind_echo_v : rsp_v_q;
  assign rsp__ENA     = rsp_ena_q;
  assign rsp_v        = rsp_v_q;
  assign err_orphan   = orphan_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      ptr_q     <= '0;
      rsp_ena_q <= '0;
      rsp_v_q   <= '0;
      orphan_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      rsp_ena_q <= rsp_ena_d;
      rsp_v_q   <= rsp_v_d;
      orphan_q  <= orphan_q | (ind_echo__ENA & empty);
    end
`ifdef ECHO_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] grant_cnt_q;
  logic [CW-1:0]         max_q;
  assign grant_cnt       = grant_cnt_q;
  assign max_outstanding = max_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      grant_cnt_q <= '0;
      max_q       <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && grant_cnt_q[i*CNT_W +: CNT_W] != '1)
          grant_cnt_q[i*CNT_W +: CNT_W] <= grant_cnt_q[i*CNT_W +: CNT_W] + 1'b1;
      max_q <= (outstanding > max_q) ? outstanding : max_q;
    end
`endif
endmodule

// File: tb/tb_echo_arbiter.sv
// tb_echo_arbiter: randomized and directed checks of echo_arbiter against a queue-based model.
module tb_echo_arbiter;
  localparam int NREQ = 4, DEPTH = 4, DW = 32, CW = 3;
  logic            CLK = 0;
  logic            nRST = 0;
  logic [NREQ-1:0] req_ena = '0;
  logic [NREQ*DW-1:0] req_v = '0;
  logic [NREQ-1:0] req_rdy;
  logic            eq_ena;
  logic [DW-1:0]   eq_v;
  logic            eq_rdy = 0;
  logic            ind = 0;
  logic [DW-1:0]   ind_v = '0;
  logic [NREQ-1:0] rsp_ena;
  logic [DW-1:0]   rsp_v;
  logic [CW-1:0]   outstanding;
  logic            err_orphan;
`ifdef ECHO_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [CW-1:0]      max_out;
`endif
  int total = 0, bad = 0;
  int ptr = 0, peak = 0;
  int tq[$];
  bit orphan = 0;
  logic [NREQ-1:0] exp_rsp_ena = '0;
  logic [DW-1:0]   exp_rsp_v = '0;
  logic [NREQ-1:0] obs_rdy;

  echo_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST), .req__ENA(req_ena), .req_v(req_v), .req__RDY(req_rdy),
    .echoReq__ENA(eq_ena), .echoReq_v(eq_v), .echoReq__RDY(eq_rdy),
    .ind_echo__ENA(ind), .ind_echo_v(ind_v), .rsp__ENA(rsp_ena), .rsp_v(rsp_v),
    .outstanding(outstanding),
`ifdef ECHO_ARB_STATS_EN
    .grant_cnt(grant_cnt), .max_outstanding(max_out),
`endif
    .err_orphan(err_orphan)
  );

  always #5 CLK = ~CLK;

  task automatic reset_model();
    ptr = 0; tq.delete(); orphan = 0; exp_rsp_ena = '0; exp_rsp_v = '0; peak = 0;
  endtask

  task automatic drive(input logic [NREQ-1:0] e, input logic r, input logic i, input logic [DW-1:0] iv);
    req_ena = e; eq_rdy = r; ind = i; ind_v = iv;
    req_v = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: check the combinational request path, clock, update the model, check registered state.
  task automatic cyc();
    int g;
    logic [NREQ-1:0] exp_rdy;
    g = -1;
    if (eq_rdy && tq.size() < DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_ena[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    #1;
    obs_rdy = req_rdy;
    total++;
    if (req_rdy !== exp_rdy) begin bad++; $display("FAIL grant: got %b want %b", req_rdy, exp_rdy); end
    total++;
    if (eq_ena !== (g >= 0)) begin bad++; $display("FAIL fwd_ena: got %b want %b", eq_ena, g >= 0); end
    if (g >= 0) begin
      total++;
      if (eq_v !== req_v[g*DW +: DW]) begin bad++; $display("FAIL fwd_v: got %h want %h", eq_v, req_v[g*DW +: DW]); end
    end
    @(posedge CLK);
    if (ind && tq.size() > 0) begin
      exp_rsp_ena = NREQ'(1 << tq.pop_front());
      exp_rsp_v = ind_v;
    end else begin
      exp_rsp_ena = '0;
      if (ind) orphan = 1;
    end
    if (g >= 0) begin tq.push_back(g); ptr = (g + 1) % NREQ; end
    if (tq.size() > peak) peak = tq.size();
    #1;
    total++;
    if (rsp_ena !== exp_rsp_ena) begin bad++; $display("FAIL rsp_ena: got %b want %b", rsp_ena, exp_rsp_ena); end
    total++;
    if (rsp_v !== exp_rsp_v) begin bad++; $display("FAIL rsp_v: got %h want %h", rsp_v, exp_rsp_v); end
    total++;
    if (outstanding !== CW'(tq.size())) begin bad++; $display("FAIL outstanding: got %0d want %0d", outstanding, tq.size()); end
    total++;
    if (err_orphan !== orphan) begin bad++; $display("FAIL err_orphan: got %b want %b", err_orphan, orphan); end
  endtask

  task automatic test_reset();
    nRST = 0;
    drive(4'hF, 1, 0, '0);
    @(posedge CLK); #1;
    total++;
    if ({req_rdy, eq_ena, rsp_ena, outstanding, err_orphan} !== '0 || rsp_v !== '0) begin
      bad++; $display("FAIL reset: rdy=%b fwd=%b rsp=%b out=%0d orph=%b rsp_v=%h want all zero", req_rdy, eq_ena, rsp_ena, outstanding, err_orphan, rsp_v);
    end
    nRST = 1;
    reset_model();
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 1, i > 0, $urandom);
      cyc();
      total++;
      if (obs_rdy !== seq[i]) begin bad++; $display("FAIL rotation[%0d]: got %b want %b", i, obs_rdy, seq[i]); end
    end
    drive('0, 1, 1, $urandom); cyc();
  endtask

  task automatic test_routing();
    drive(4'b0100, 1, 0, '0);
    req_v[2*DW +: DW] = 32'hDEAD0002;
    cyc();
    for (int i = 0; i < 2; i++) begin drive('0, 1, 0, '0); cyc(); end
    drive('0, 1, 1, 32'hDEAD0002); cyc();
    total++;
    if (rsp_ena !== 4'b0100 || rsp_v !== 32'hDEAD0002) begin
      bad++; $display("FAIL routing: got %b/%h want 0100/dead0002", rsp_ena, rsp_v);
    end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < DEPTH; i++) begin drive(4'h1, 1, 0, '0); cyc(); end
    total++;
    if (outstanding !== CW'(DEPTH)) begin bad++; $display("FAIL full_count: got %0d want %0d", outstanding, DEPTH); end
    drive(4'h1, 1, 1, $urandom); cyc();
    total++;
    if (obs_rdy !== '0 || outstanding !== 3'd3) begin
      bad++; $display("FAIL full_pop_same_cycle: rdy=%b out=%0d want 0000/3", obs_rdy, outstanding);
    end
    drive(4'h1, 1, 0, '0); cyc();
    total++;
    if (obs_rdy !== 4'b0001) begin bad++; $display("FAIL full_next_grant: got %b want 0001", obs_rdy); end
    for (int i = 0; i < DEPTH; i++) begin drive('0, 1, 1, $urandom); cyc(); end
  endtask

  task automatic test_orphan();
    drive('0, 1, 1, $urandom); cyc();
    for (int i = 0; i < 2; i++) begin drive('0, 1, 0, '0); cyc(); end
    total++;
    if (rsp_ena !== '0 || err_orphan !== 1'b1) begin
      bad++; $display("FAIL orphan: rsp=%b orph=%b want 0000/1", rsp_ena, err_orphan);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(NREQ'($urandom), ($urandom % 4) != 0, ($urandom % 2) == 0, $urandom);
      cyc();
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i <= DEPTH && tq.size() > 0; i++) begin drive('0, 1, 1, $urandom); cyc(); end
    for (int i = 0; i < 2; i++) begin drive(4'h3, 1, 0, '0); cyc(); end
    drive(4'hF, 1, 0, '0);
    #2 nRST = 0;
    #1;
    total++;
    if ({req_rdy, eq_ena, rsp_ena, outstanding, err_orphan} !== '0 || rsp_v !== '0) begin
      bad++; $display("FAIL reset_midflight: rdy=%b fwd=%b rsp=%b out=%0d orph=%b rsp_v=%h want all zero", req_rdy, eq_ena, rsp_ena, outstanding, err_orphan, rsp_v);
    end
    reset_model();
    @(posedge CLK); #1 nRST = 1;
    drive('0, 1, 1, $urandom); cyc();
  endtask

`ifdef ECHO_ARB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 5; i++) begin drive(4'b0010, 1, i > 0, $urandom); cyc(); end
    drive('0, 1, 1, $urandom); cyc();
    drive('0, 1, 0, '0); cyc();
    total++;
    if (grant_cnt !== {16'd0, 16'd0, 16'd5, 16'd0}) begin bad++; $display("FAIL grant_cnt: got %h want 5 for requester 1", grant_cnt); end
    total++;
    if (max_out !== CW'(peak)) begin bad++; $display("FAIL max_outstanding: got %0d want %0d", max_out, peak); end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_routing();
    test_full_stall();
    test_orphan();
    test_random();
    test_reset_midflight();
`ifdef ECHO_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/echo_arbiter.md
# echo_arbiter

Round-robin arbiter sharing one echo engine's `echoReq` method among `NREQ` requesters. It returns each `ind_echo` indication to the requester that issued the matching request. It sits between the requester ports and the echo block, adds no latency on the request path, and keeps an in-order tag queue of outstanding requests. Responses route back on that tag queue because the echo path is strictly FIFO-ordered.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DEPTH`, 4, maximum outstanding requests; power of two, 2..16
- `DATA_W`, 32, payload width
- `CLK`  in  1  clock
- `nRST`  in  1  reset, asynchronous, active-low
- `req__ENA`  in  NREQ  per-requester request valid
- `req_v`  in  NREQ*DATA_W  payloads; requester i occupies bits `[i*DATA_W +: DATA_W]`
- `req__RDY`  out  NREQ  one-hot grant; transfer when `req__ENA[i] & req__RDY[i]`
- `echoReq__ENA`  out  1  forward to echo engine
- `echoReq_v`  out  DATA_W  forwarded payload
- `echoReq__RDY`  in  1  echo engine can accept
- `ind_echo__ENA`  in  1  echo indication strobe; no backpressure
- `ind_echo_v`  in  DATA_W  echoed payload
- `rsp__ENA`  out  NREQ  one-hot response strobe
- `rsp_v`  out  DATA_W  response payload
- `outstanding`  out  $clog2(DEPTH)+1  count of issued requests not yet answered
- `err_orphan`  out  1  sticky: an indication arrived with the tag queue empty

## Operation
- **Eligibility.** Requester i is eligible when `req__ENA[i]`, `echoReq__RDY`, and the tag queue is not full all hold.
- **Grant.** The grant is combinational and round-robin. The search starts at pointer `ptr` and wraps modulo NREQ. At most one `req__RDY` bit is high.
- **No grant possible.** When the queue is full or `echoReq__RDY` is low, all `req__RDY` bits are 0, independent of `req__ENA`.
- **Issue.**
  - On a grant to requester g: `echoReq__ENA`=1, `echoReq_v`=`req_v[g]`.
  - Tag g is pushed into the tag queue.
  - `ptr` ← (g+1) mod NREQ.
  - With no grant, `ptr` holds its value.
- **Return.**
  - On `ind_echo__ENA` the head tag t is popped.
  - Next cycle: `rsp__ENA` = one-hot(t), `rsp_v` = `ind_echo_v`, both registered. Otherwise `rsp__ENA` = 0 and `rsp_v` holds its value.
- **Push and pop in the same cycle.** Both take effect; `outstanding` is unchanged.
- **Full queue.** Fullness is evaluated on the registered count. A same-cycle pop does not permit a grant.
- **Orphan indication.** `ind_echo__ENA` with an empty queue produces no response and leaves the queue unchanged. `err_orphan` is set and stays set until reset.
- **Reset (async assert, sync deassert expected at the system level).**
  - `ptr`=0, queue empty, `outstanding`=0.
  - `rsp__ENA`=0, `rsp_v`=0, `err_orphan`=0.
  - Outstanding tags are discarded mid-operation; later indications count as orphans.
- **Combinational outputs under reset.** `req__RDY` and `echoReq__ENA` are forced to 0 while `nRST`=0.

## Timing
- Request path: zero cycles; grant, forward and push occur in the same cycle as the transfer.
- Response path: one cycle from `ind_echo__ENA` to `rsp__ENA`.
- Throughput: one request and one response per cycle, sustained.
- `outstanding` is registered and reflects pushes and pops from the previous edge.

## Configuration
- Macro: `ECHO_ARB_STATS_EN`.
- **Defined:**
  - Adds output `grant_cnt`, NREQ*16 bits: per-requester 16-bit grant counters that saturate at 0xFFFF.
  - Adds output `max_outstanding`: the high-water mark of `outstanding`.
  - All counters reset to 0.
- **Undefined:** neither port exists and no counter logic is generated. Arbitration behaviour is identical either way.

## Structure
- **Package `echo_arb_pkg`:**
  - `DATA_W` default
  - `tag_t`, a requester index sized for NREQ max 8
  - counter width constant (16)
  - helper function `onehot_of(tag)`
- **Sub-module `echo_arb_tagq`:**
  - synchronous-push, synchronous-pop FIFO of `tag_t`, DEPTH entries
  - ports: `full`, `empty`, `count`, `head`
  - asynchronous active-low reset clears pointers only
- **Top level:** grant logic, pointer, and response register.

## Test plan
- **Rotation:** all four requesters assert continuously with `echoReq__RDY`=1. Grants run 0,1,2,3,0; `ptr` wraps 3→0.
- **Routing:** requester 2 sends 0xDEAD0002, then the echo engine returns it 3 cycles later. One cycle after `ind_echo__ENA`, `rsp__ENA`=4'b0100 and `rsp_v`=0xDEAD0002.
- **Full stall:** DEPTH=4 requests issue with no indication, so `outstanding`=4 and all `req__RDY`=0. Then indication and request arrive in the same cycle: no grant that cycle, `outstanding`=3 after the edge, and the grant is given the following cycle.
- **Orphan:** `ind_echo__ENA` is pulsed at idle. `rsp__ENA` stays 0 and `err_orphan`=1 stays high.
- **Reset mid-flight:** 2 requests are outstanding and `nRST` is pulsed low. All outputs immediately show reset values and `outstanding`=0.
- **Stats (macro defined):** 5 grants to requester 1 give `grant_cnt[1]`=5, and `max_outstanding` equals the peak reached.
